// File: rtl/dc_fifo_if.sv
// Handshake/data bundle between a dc_fifo and its user.
// The master side drives write data and requests; the slave side is the FIFO.
interface dc_fifo_if #(
    parameter int LPM_WIDTH  = 8,
    parameter int LPM_WIDTHU = 2
) ();
    logic [LPM_WIDTH-1:0]  data;
    logic                  wrreq;
    logic                  rdreq;
    logic [LPM_WIDTH-1:0]  q;
    logic                  rdempty;
    logic                  wrfull;
    logic [LPM_WIDTHU-1:0] rdusedw;
    logic [LPM_WIDTHU-1:0] wrusedw;

    modport master (
        output data, wrreq, rdreq,
        input  q, rdempty, wrfull, rdusedw, wrusedw
    );

    modport slave (
        input  data, wrreq, rdreq,
        output q, rdempty, wrfull, rdusedw, wrusedw
    );
endinterface

// File: rtl/dc_fifo.sv
// Single-clock register-array FIFO with a registered occupancy count,
// asynchronous active-low reset and selectable normal / show-ahead read port.
module dc_fifo #(
    parameter int              LPM_WIDTH     = 8,
    parameter int              LPM_NUMWORDS  = 4,
    parameter int              LPM_WIDTHU    = 2,
    parameter logic [8*3-1:0]  LPM_SHOWAHEAD = "OFF"
) (
    input  logic     clk,
    input  logic     reset_n,
    dc_fifo_if.slave bus
);
    localparam logic [8*3-1:0]        MODE_ON    = 24'("ON");
    localparam bit                    SHOW_AHEAD = (LPM_SHOWAHEAD == MODE_ON);
    localparam logic [LPM_WIDTHU:0]   CNT_FULL   = (LPM_WIDTHU+1)'(LPM_NUMWORDS);
    localparam logic [LPM_WIDTHU:0]   CNT_ONE    = (LPM_WIDTHU+1)'(1);
    localparam logic [LPM_WIDTHU-1:0] PTR_ONE    = LPM_WIDTHU'(1);

    logic [LPM_WIDTH-1:0]  mem_q [LPM_NUMWORDS];
    logic [LPM_WIDTHU-1:0] wptr_q, wptr_d;
    logic [LPM_WIDTHU-1:0] rptr_q, rptr_d;
    logic [LPM_WIDTHU:0]   cnt_q,  cnt_d;
    logic [LPM_WIDTH-1:0]  q_q,    q_d;

    logic                  empty;
    logic                  full;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [LPM_WIDTH-1:0]  head;

    // Flags come straight from the registered count, so they move on the
    // same edge as the count and fall immediately with reset.
    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == CNT_FULL);
    assign wr_acc = bus.wrreq && !full;
    assign rd_acc = bus.rdreq && !empty;
    assign head   = mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        q_d    = q_q;
        if (wr_acc) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rptr_d = rptr_q + PTR_ONE;
            q_d    = head;
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage is deliberately left out of reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_acc && reset_n) begin
            mem_q[wptr_q] <= bus.data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            q_q    <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            q_q    <= q_d;
        end
    end

    // Show-ahead exposes the head word directly; while empty it falls back
    // to the last popped word (0 after reset), which is a don't-care there.
    generate
        if (SHOW_AHEAD) begin : g_show_ahead
            assign bus.q = empty ? q_q : head;
        end else begin : g_normal
            assign bus.q = q_q;
        end
    endgenerate

    assign bus.rdempty = empty;
    assign bus.wrfull  = full;
    assign bus.rdusedw = cnt_q[LPM_WIDTHU-1:0];
    assign bus.wrusedw = cnt_q[LPM_WIDTHU-1:0];

    a_cnt_bound: assert property (@(posedge clk) disable iff (!reset_n)
        cnt_q <= CNT_FULL);
    a_ptr_gap: assert property (@(posedge clk) disable iff (!reset_n)
        (wptr_q - rptr_q) == cnt_q[LPM_WIDTHU-1:0]);
endmodule

// File: tb/tb_dc_fifo.sv
// Self-checking bench for dc_fifo: directed scenarios plus a randomized run,
// all compared against a queue-based reference model.
module tb_dc_fifo;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int WU = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dc_fifo_if #(.LPM_WIDTH(W), .LPM_WIDTHU(WU)) bus ();
    dc_fifo_if #(.LPM_WIDTH(W), .LPM_WIDTHU(WU)) bus_sa ();

    dc_fifo #(.LPM_WIDTH(W), .LPM_NUMWORDS(N), .LPM_WIDTHU(WU), .LPM_SHOWAHEAD("OFF"))
        dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    dc_fifo #(.LPM_WIDTH(W), .LPM_NUMWORDS(N), .LPM_WIDTHU(WU), .LPM_SHOWAHEAD("ON"))
        dut_sa (.clk(clk), .reset_n(reset_n), .bus(bus_sa));

    assign bus_sa.data  = bus.data;
    assign bus_sa.wrreq = bus.wrreq;
    assign bus_sa.rdreq = bus.rdreq;

    logic [W-1:0] mq[$];
    logic [W-1:0] q_exp = '0;
    int total = 0;
    int bad = 0;

    // One clock of stimulus; the model applies the FIFO rules to its queue.
    task automatic step(input bit wr, input bit rd, input logic [W-1:0] d);
        bit wr_ok, rd_ok;
        @(negedge clk);
        bus.wrreq = wr;
        bus.rdreq = rd;
        bus.data  = d;
        @(posedge clk);
        wr_ok = wr && (mq.size() < N) && reset_n;
        rd_ok = rd && (mq.size() > 0) && reset_n;
        if (rd_ok) q_exp = mq.pop_front();
        if (wr_ok) mq.push_back(d);
        #1;
    endtask

    task automatic test_reset();
        bus.wrreq = 1'b0; bus.rdreq = 1'b0; bus.data = '0;
        reset_n = 1'b0;
        step(1'b1, 1'b1, 8'hEE);
        total++; if (bus.rdempty !== 1'b1) begin bad++; $display("FAIL reset_rdempty got=%b want=1", bus.rdempty); end
        total++; if (bus.wrfull !== 1'b0) begin bad++; $display("FAIL reset_wrfull got=%b want=0", bus.wrfull); end
        total++; if (bus.rdusedw !== 2'd0 || bus.wrusedw !== 2'd0) begin bad++; $display("FAIL reset_usedw got=%0d/%0d want=0", bus.rdusedw, bus.wrusedw); end
        total++; if (bus.q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h want=00", bus.q); end
        @(negedge clk);
        bus.wrreq = 1'b0; bus.rdreq = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        step(1'b1, 1'b0, 8'hA1);
        total++; if (bus.rdempty !== 1'b0) begin bad++; $display("FAIL single_rdempty got=%b want=0", bus.rdempty); end
        total++; if (bus.rdusedw !== 2'd1) begin bad++; $display("FAIL single_usedw got=%0d want=1", bus.rdusedw); end
        total++; if (bus_sa.q !== 8'hA1) begin bad++; $display("FAIL single_showahead got=%h want=a1", bus_sa.q); end
        step(1'b0, 1'b1, 8'h00);
        total++; if (bus.q !== 8'hA1) begin bad++; $display("FAIL single_q got=%h want=a1", bus.q); end
        total++; if (bus.rdempty !== 1'b1 || bus.wrusedw !== 2'd0) begin bad++; $display("FAIL single_drain got empty=%b usedw=%0d want empty=1 usedw=0", bus.rdempty, bus.wrusedw); end
    endtask

    task automatic test_fill();
        logic [W-1:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        foreach (words[i]) step(1'b1, 1'b0, words[i]);
        total++; if (bus.wrfull !== 1'b1 || bus.rdusedw !== 2'd0) begin bad++; $display("FAIL fill_full got full=%b usedw=%0d want full=1 usedw=0", bus.wrfull, bus.rdusedw); end
        step(1'b1, 1'b0, 8'h55);
        total++; if (bus.wrfull !== 1'b1 || bus.rdempty !== 1'b0) begin bad++; $display("FAIL fill_overflow got full=%b empty=%b want full=1 empty=0", bus.wrfull, bus.rdempty); end
        foreach (words[i]) begin
            step(1'b0, 1'b1, 8'h00);
            total++; if (bus.q !== words[i]) begin bad++; $display("FAIL fill_order[%0d] got=%h want=%h", i, bus.q, words[i]); end
        end
        total++; if (bus.rdempty !== 1'b1 || bus.wrfull !== 1'b0) begin bad++; $display("FAIL fill_empty got empty=%b full=%b want empty=1 full=0", bus.rdempty, bus.wrfull); end
    endtask

    task automatic test_empty_read();
        step(1'b0, 1'b1, 8'h00);
        total++; if (bus.q !== 8'h44) begin bad++; $display("FAIL empty_read_q got=%h want=44", bus.q); end
        total++; if (bus.rdempty !== 1'b1 || bus.rdusedw !== 2'd0) begin bad++; $display("FAIL empty_read_state got empty=%b usedw=%0d want empty=1 usedw=0", bus.rdempty, bus.rdusedw); end
        step(1'b1, 1'b0, 8'h66);
        step(1'b0, 1'b1, 8'h00);
        total++; if (bus.q !== 8'h66) begin bad++; $display("FAIL empty_read_after got=%h want=66", bus.q); end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 8'($urandom));
            total++; if (bus.rdusedw !== 2'd2) begin bad++; $display("FAIL b2b_usedw[%0d] got=%0d want=2", i, bus.rdusedw); end
            total++; if (bus.q !== q_exp) begin bad++; $display("FAIL b2b_q[%0d] got=%h want=%h", i, bus.q, q_exp); end
            total++; if (bus_sa.q !== mq[0]) begin bad++; $display("FAIL b2b_showahead[%0d] got=%h want=%h", i, bus_sa.q, mq[0]); end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 8'h00);
            total++; if (bus.q !== q_exp) begin bad++; $display("FAIL b2b_drain[%0d] got=%h want=%h", i, bus.q, q_exp); end
        end
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b1, 8'hCC);
        total++; if (bus.rdusedw !== 2'd3 || bus.wrfull !== 1'b0) begin bad++; $display("FAIL full_simul_state got usedw=%0d full=%b want usedw=3 full=0", bus.rdusedw, bus.wrfull); end
        total++; if (bus.q !== q_exp) begin bad++; $display("FAIL full_simul_q got=%h want=%h", bus.q, q_exp); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h00);
            total++; if (bus.q !== q_exp) begin bad++; $display("FAIL full_simul_drain[%0d] got=%h want=%h", i, bus.q, q_exp); end
        end
        total++; if (bus.rdempty !== 1'b1) begin bad++; $display("FAIL full_simul_empty got=%b want=1", bus.rdempty); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom));
        step(1'b0, 1'b1, 8'h00);
        #2;
        reset_n = 1'b0;
        #1;
        mq.delete();
        q_exp = '0;
        total++; if (bus.rdempty !== 1'b1 || bus.wrfull !== 1'b0) begin bad++; $display("FAIL async_reset_flags got empty=%b full=%b want empty=1 full=0", bus.rdempty, bus.wrfull); end
        total++; if (bus.q !== 8'h00 || bus.rdusedw !== 2'd0) begin bad++; $display("FAIL async_reset_q got q=%h usedw=%0d want q=00 usedw=0", bus.q, bus.rdusedw); end
        step(1'b1, 1'b0, 8'hEE);
        total++; if (bus.rdempty !== 1'b1) begin bad++; $display("FAIL async_reset_ignore got=%b want=1", bus.rdempty); end
        @(negedge clk);
        bus.wrreq = 1'b1; bus.rdreq = 1'b0; bus.data = 8'h5A;
        reset_n = 1'b1;
        @(posedge clk);
        mq.push_back(8'h5A);
        #1;
        total++; if (bus.rdempty !== 1'b0 || bus.rdusedw !== 2'd1) begin bad++; $display("FAIL async_reset_first got empty=%b usedw=%0d want empty=0 usedw=1", bus.rdempty, bus.rdusedw); end
        step(1'b0, 1'b1, 8'h00);
        total++; if (bus.q !== 8'h5A || bus.rdempty !== 1'b1) begin bad++; $display("FAIL async_reset_new got q=%h empty=%b want q=5a empty=1", bus.q, bus.rdempty); end
    endtask

    task automatic test_random();
        bit wr, rd;
        for (int i = 0; i < 400; i++) begin
            wr = ($urandom_range(0, 99) < ((i < 200) ? 60 : 40));
            rd = ($urandom_range(0, 99) < ((i < 200) ? 40 : 60));
            step(wr, rd, 8'($urandom));
            total++; if (bus.rdempty !== (mq.size() == 0)) begin bad++; $display("FAIL rand_rdempty[%0d] got=%b want=%b", i, bus.rdempty, mq.size() == 0); end
            total++; if (bus.wrfull !== (mq.size() == N)) begin bad++; $display("FAIL rand_wrfull[%0d] got=%b want=%b", i, bus.wrfull, mq.size() == N); end
            total++; if (bus.rdusedw !== 2'(mq.size() % N) || bus.wrusedw !== 2'(mq.size() % N)) begin bad++; $display("FAIL rand_usedw[%0d] got=%0d/%0d want=%0d", i, bus.rdusedw, bus.wrusedw, mq.size() % N); end
            total++; if (bus.q !== q_exp) begin bad++; $display("FAIL rand_q[%0d] got=%h want=%h", i, bus.q, q_exp); end
            if (mq.size() != 0) begin
                total++; if (bus_sa.q !== mq[0]) begin bad++; $display("FAIL rand_showahead[%0d] got=%h want=%h", i, bus_sa.q, mq[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_empty_read();
        test_back_to_back();
        test_full_simul();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
